// File: rtl/shader_loader_if.sv
// rtl/shader_loader_if.sv - shader memory write port shared by loader, memory and core
// Purpose: bundles the memory shift/load/instr port with the core's fetch shift
//          request and the busy stall back to the core.
// Signals:
//   exec_shift  core -> loader : circular fetch shift request
//   shift       loader -> mem  : memory shift strobe
//   load        loader -> mem  : memory load strobe (replace shifted-in word)
//   instr[7:0]  loader -> mem  : instruction word to load
//   busy        loader -> core : load in progress, core must not request shifts
interface shader_loader_if;
    logic       exec_shift;
    logic       shift;
    logic       load;
    logic [7:0] instr;
    logic       busy;

    modport master (
        input  exec_shift,
        output shift,
        output load,
        output instr,
        output busy
    );

    modport slave (
        output exec_shift,
        input  shift,
        input  load,
        input  instr,
        input  busy
    );
endinterface

// File: rtl/shader_loader.sv
// rtl/shader_loader.sv - SPI mode-0 receiver that writes shader programs into shader memory
// Purpose: deserialises MOSI bytes (MSB first) clocked by an asynchronous SPI
//          clock, and turns each completed byte into one memory load cycle,
//          merged with the core's circular fetch shifts.
// Ports:
//   clk_i         system clock, the only clock
//   rst_i         synchronous active-high reset
//   spi_sclk_i    async SPI clock, sampled on its rising edge (f_sclk <= f_clk/4)
//   spi_mosi_i    async SPI data, MSB first
//   spi_csn_i     async SPI chip select, active-low
//   mem           shader_loader_if master: exec_shift in; shift/load/instr/busy out
//   done_o        1-cycle pulse after the write that wraps byte_count_o
//   overrun_o     sticky until next frame start: a byte was dropped
//   byte_count_o  writes in the current frame, modulo NUM_INSTR
module shader_loader #(
    parameter int  NUM_INSTR = 8,
    localparam int CW        = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            spi_sclk_i,
    input  logic            spi_mosi_i,
    input  logic            spi_csn_i,
    shader_loader_if.master mem,
    output logic            done_o,
    output logic            overrun_o,
    output logic [CW-1:0]   byte_count_o
);

    localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_INSTR - 1);

    // Two-flop synchronisers plus one history flop for edge detection.
    logic r_sclk_m, r_sclk_s, r_sclk_q;
    logic r_csn_m,  r_csn_s,  r_csn_q;
    logic r_mosi_m, r_mosi_s;

    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shreg;
    logic [7:0]    r_byte_q;
    logic          r_pending_q;
    logic [CW-1:0] r_byte_count;
    logic          r_done;
    logic          r_overrun;
    logic          r_busy;

    logic       w_sclk_rise;
    logic       w_csn_fall;
    logic       w_csn_rise;
    logic [7:0] w_byte;
    logic       w_byte_done;
    logic       w_wr;

    assign w_sclk_rise = r_sclk_s & ~r_sclk_q;
    assign w_csn_fall  = ~r_csn_s & r_csn_q;
    assign w_csn_rise  = r_csn_s & ~r_csn_q;
    assign w_byte      = {r_shreg[6:0], r_mosi_s};
    // Eighth bit of a byte arrives; frame boundaries take precedence.
    assign w_byte_done = w_sclk_rise & ~r_csn_s & ~w_csn_fall & (r_bit_cnt == 3'd7);
    // The core's fetch shift wins; a pending byte simply waits for a free cycle.
    assign w_wr        = r_pending_q & ~mem.exec_shift;

    always_comb begin
        mem.shift = mem.exec_shift;
        mem.load  = 1'b0;
        mem.instr = 8'h00;
        if (!rst_i) begin
            mem.load  = w_wr;
            mem.shift = w_wr | mem.exec_shift;
            mem.instr = r_byte_q;
        end
    end

    assign mem.busy     = r_busy;
    assign done_o       = r_done;
    assign overrun_o    = r_overrun;
    assign byte_count_o = r_byte_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sclk_m     <= 1'b0;
            r_sclk_s     <= 1'b0;
            r_sclk_q     <= 1'b0;
            r_csn_m      <= 1'b1;
            r_csn_s      <= 1'b1;
            r_csn_q      <= 1'b1;
            r_mosi_m     <= 1'b0;
            r_mosi_s     <= 1'b0;
            r_bit_cnt    <= 3'd0;
            r_shreg      <= 8'h00;
            r_byte_q     <= 8'h00;
            r_pending_q  <= 1'b0;
            r_byte_count <= '0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_sclk_m <= spi_sclk_i;
            r_sclk_s <= r_sclk_m;
            r_sclk_q <= r_sclk_s;
            r_csn_m  <= spi_csn_i;
            r_csn_s  <= r_csn_m;
            r_csn_q  <= r_csn_s;
            r_mosi_m <= spi_mosi_i;
            r_mosi_s <= r_mosi_m;

            // Either frame edge restarts bit alignment; a partial byte is lost.
            if (w_csn_fall || w_csn_rise) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sclk_rise && !r_csn_s) begin
                r_shreg   <= w_byte;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            // Only one byte of buffering: a byte completing while the previous
            // one is still pending is dropped rather than corrupting byte_q.
            if (w_byte_done && !r_pending_q) begin
                r_byte_q    <= w_byte;
                r_pending_q <= 1'b1;
            end else if (w_wr) begin
                r_pending_q <= 1'b0;
            end

            if (w_csn_fall) begin
                r_overrun <= 1'b0;
            end else if (w_byte_done && r_pending_q) begin
                r_overrun <= 1'b1;
            end

            if (w_csn_fall) begin
                r_byte_count <= '0;
            end else if (w_wr) begin
                r_byte_count <= (r_byte_count == LAST_COUNT) ? '0 : r_byte_count + 1'b1;
            end

            r_done <= w_wr && (r_byte_count == LAST_COUNT);
            r_busy <= ~r_csn_s | r_pending_q;
        end
    end

endmodule

// File: tb/tb_shader_loader.sv
// tb/tb_shader_loader.sv - self-checking bench for shader_loader
`timescale 1ns/1ps
module tb_shader_loader;

    typedef struct {
        int           n;
        logic [127:0] b;          // byte i at [127-8*i -: 8]
        int           exp_loads;
        int           exp_done;
        int           exp_count;
    } frame_t;

    logic       clk;
    logic       rst;
    logic       sclk;
    logic       mosi;
    logic       csn;
    logic       done;
    logic       ovr;
    logic [2:0] cnt;

    int         checks;
    int         errors;
    int         done_cnt;
    logic [7:0] wr_q[$];
    frame_t     tbl[5];

    shader_loader_if u_if();

    shader_loader #(.NUM_INSTR(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .spi_sclk_i   (sclk),
        .spi_mosi_i   (mosi),
        .spi_csn_i    (csn),
        .mem          (u_if.master),
        .done_o       (done),
        .overrun_o    (ovr),
        .byte_count_o (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory-side observer: records every load and checks the shift merge rule.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_load", u_if.load, 1'b0);
            chk("rst_instr", u_if.instr, 8'h00);
            chk("rst_shift", u_if.shift, u_if.exec_shift);
        end else begin
            if (u_if.load) begin
                chk("shift_on_load", u_if.shift, 1'b1);
                wr_q.push_back(u_if.instr);
            end else begin
                chk("shift_follow", u_if.shift, u_if.exec_shift);
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // SCLK period is four system clocks, the fastest the receiver supports.
    task automatic spi_bits(input logic [7:0] v, input int nb);
        for (int k = 7; k > 7 - nb; k--) begin
            mosi = v[k];
            sclk = 1'b0;
            tick(2);
            sclk = 1'b1;
            tick(2);
        end
        sclk = 1'b0;
        tick(2);
    endtask

    task automatic send_frame(input logic [127:0] b, input int n);
        csn = 1'b0;
        tick(4);
        for (int i = 0; i < n; i++) spi_bits(b[127-8*i -: 8], 8);
        tick(4);
        csn = 1'b1;
        tick(10);
    endtask

    task automatic check_frame(input string tag, input logic [127:0] b, input int n,
                               input int base, input int dbase, input int exp_loads,
                               input int exp_done, input int exp_count);
        int got;
        got = wr_q.size() - base;
        chk($sformatf("%s_loads", tag), got, exp_loads);
        for (int i = 0; i < n && i < got; i++)
            chk($sformatf("%s_data%0d", tag, i), wr_q[base+i], b[127-8*i -: 8]);
        chk($sformatf("%s_done", tag), done_cnt - dbase, exp_done);
        chk($sformatf("%s_count", tag), cnt, exp_count);
        chk($sformatf("%s_ovr", tag), ovr, 1'b0);
    endtask

    initial begin
        int           base;
        int           dbase;
        int           n;
        logic [127:0] rb;

        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        rst  = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        csn  = 1'b1;
        u_if.exec_shift = 1'b0;

        tbl[0] = '{8,  128'h10157400_70707070_00000000_00000000, 8,  1, 0};
        tbl[1] = '{3,  128'hA55AFF00_00000000_00000000_00000000, 3,  0, 3};
        tbl[2] = '{10, 128'h01020304_05060708_090A0000_00000000, 10, 1, 2};
        tbl[3] = '{1,  128'h00000000_00000000_00000000_00000000, 1,  0, 1};
        tbl[4] = '{16, 128'h80402010_08040201_FEFDFBF7_EFDFBF7F, 16, 2, 0};

        tick(3);
        rst = 1'b0;
        tick(1);
        chk("init_count", cnt, 3'd0);
        chk("init_done", done, 1'b0);
        chk("init_ovr", ovr, 1'b0);
        chk("init_busy", u_if.busy, 1'b0);
        chk("init_load", u_if.load, 1'b0);
        chk("init_instr", u_if.instr, 8'h00);

        // Table-driven frames with exec_shift idle.
        for (int r = 0; r < 5; r++) begin
            base  = wr_q.size();
            dbase = done_cnt;
            send_frame(tbl[r].b, tbl[r].n);
            check_frame($sformatf("tbl%0d", r), tbl[r].b, tbl[r].n, base, dbase,
                        tbl[r].exp_loads, tbl[r].exp_done, tbl[r].exp_count);
        end

        // Fetch shift held across byte completion: load waits, nothing lost.
        base = wr_q.size();
        csn = 1'b0;
        tick(4);
        spi_bits(8'h3C, 7);
        mosi = 1'b0;
        tick(2);
        u_if.exec_shift = 1'b1;
        sclk = 1'b1;
        tick(5);
        chk("hold_busy", u_if.busy, 1'b1);
        chk("hold_withheld", wr_q.size() - base, 0);
        u_if.exec_shift = 1'b0;
        @(negedge clk);
        chk("hold_first_low_load", u_if.load, 1'b1);
        chk("hold_first_low_instr", u_if.instr, 8'h3C);
        tick(1);
        sclk = 1'b0;
        tick(4);
        csn = 1'b1;
        tick(10);
        chk("hold_loads", wr_q.size() - base, 1);
        chk("hold_count", cnt, 3'd1);

        // Partial byte then a fresh frame.
        base = wr_q.size();
        csn = 1'b0;
        tick(4);
        spi_bits(8'hFF, 5);
        csn = 1'b1;
        tick(10);
        chk("partial_noload", wr_q.size() - base, 0);
        base  = wr_q.size();
        dbase = done_cnt;
        send_frame(128'hA5000000_00000000_00000000_00000000, 1);
        check_frame("after_partial", 128'hA5000000_00000000_00000000_00000000, 1,
                    base, dbase, 1, 0, 1);

        // Two bytes complete under a held fetch shift: second is dropped.
        base = wr_q.size();
        csn = 1'b0;
        u_if.exec_shift = 1'b1;
        tick(4);
        spi_bits(8'h11, 8);
        spi_bits(8'h22, 8);
        tick(4);
        chk("ovr_set", ovr, 1'b1);
        chk("ovr_noload", wr_q.size() - base, 0);
        u_if.exec_shift = 1'b0;
        tick(4);
        chk("ovr_loads", wr_q.size() - base, 1);
        chk("ovr_data", (wr_q.size() > base) ? wr_q[base] : 8'hxx, 8'h11);
        csn = 1'b1;
        tick(6);
        chk("ovr_sticky", ovr, 1'b1);
        csn = 1'b0;
        tick(6);
        chk("ovr_clear", ovr, 1'b0);
        chk("ovr_count_clear", cnt, 3'd0);
        csn = 1'b1;
        tick(6);

        // Reset mid-byte.
        base = wr_q.size();
        csn = 1'b0;
        tick(4);
        spi_bits(8'hAA, 4);
        rst = 1'b1;
        csn = 1'b1;
        u_if.exec_shift = 1'b1;
        tick(2);
        u_if.exec_shift = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(10);
        chk("rst_mid_noload", wr_q.size() - base, 0);
        chk("rst_mid_count", cnt, 3'd0);
        chk("rst_mid_busy", u_if.busy, 1'b0);
        base  = wr_q.size();
        dbase = done_cnt;
        send_frame(tbl[1].b, tbl[1].n);
        check_frame("rst_mid_next", tbl[1].b, tbl[1].n, base, dbase, 3, 0, 3);

        // Reset with a byte pending.
        base = wr_q.size();
        u_if.exec_shift = 1'b1;
        csn = 1'b0;
        tick(4);
        spi_bits(8'h77, 8);
        tick(4);
        chk("rst_pend_busy", u_if.busy, 1'b1);
        rst = 1'b1;
        csn = 1'b1;
        u_if.exec_shift = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(10);
        chk("rst_pend_noload", wr_q.size() - base, 0);
        base  = wr_q.size();
        dbase = done_cnt;
        send_frame(tbl[0].b, tbl[0].n);
        check_frame("rst_pend_next", tbl[0].b, tbl[0].n, base, dbase, 8, 1, 0);

        // Random frames against the arithmetic model: every byte written in
        // order, count = n mod 8, one done per 8 writes, no overrun.
        for (int f = 0; f < 6; f++) begin
            n  = $urandom_range(1, 12);
            rb = '0;
            for (int i = 0; i < n; i++) rb[127-8*i -: 8] = 8'($urandom_range(0, 255));
            base  = wr_q.size();
            dbase = done_cnt;
            send_frame(rb, n);
            check_frame($sformatf("rnd%0d", f), rb, n, base, dbase, n, n / 8, n % 8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
